sync_fifo_drain: RTL and testbench



---
 rtl/sync_fifo_drain_pkg.sv | 6 +
 rtl/sync_fifo_drain_skid.sv | 44 ++++
 rtl/sync_fifo_drain.sv | 89 ++++++++
 tb/tb_sync_fifo_drain.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_drain_pkg.sv
// sync_fifo_drain_pkg: shared state encoding and sizes for the FIFO drain master.
package sync_fifo_drain_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FLUSH = 2'd2, DONE = 2'd3} state_t;
    localparam logic [1:0] SKID_DEPTH = 2'd2;
    localparam int STALL_W = 16;
endpackage

// File: rtl/sync_fifo_drain_skid.sv
// sync_fifo_drain_skid: 2-entry in-order skid buffer absorbing the FIFO read latency.
module sync_fifo_drain_skid
    import sync_fifo_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] data_in,
    input  logic         pop,
    output logic [W-1:0] data_out,
    output logic [1:0]   count
);
    logic [W-1:0] head_q, head_d, tail_q, tail_d;
    logic [1:0]   count_q, count_d, idx;

    // Slot the incoming word lands in once this cycle's pop has been applied.
    assign idx = count_q - {1'b0, pop};

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
        head_d  = (push && idx == 2'd0) ? data_in : (pop && count_q == SKID_DEPTH) ? tail_q : head_q;
        tail_d  = (push && idx == 2'd1) ? data_in : tail_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign data_out = head_q;
    assign count    = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == SKID_DEPTH));
endmodule

// File: rtl/sync_fifo_drain.sv
// sync_fifo_drain: pops burst_len words from a registered-read FIFO onto a valid/ready stream.
// Optional SYNC_FIFO_DRAIN_STALL_CNT_EN adds a saturating stall_cycles counter.
module sync_fifo_drain
    import sync_fifo_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [CNT_W-1:0]      burst_len,
    output logic                  busy,
    output logic                  done,
    output logic                  fifo_r_en,
    input  logic                  fifo_empty,
    input  logic [FIFO_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [FIFO_WIDTH-1:0] m_data,
`ifdef SYNC_FIFO_DRAIN_STALL_CNT_EN
    output logic [STALL_W-1:0]    stall_cycles,
`endif
    output logic [CNT_W-1:0]      words_out
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d, words_q, words_d;
    logic             inflight_q;
    logic [1:0]       count;
    logic             go, hs;

    assign go        = start && state_q == IDLE;
    assign hs        = m_valid && m_ready;
    assign m_valid   = count != 2'd0;
    assign busy      = state_q == RUN || state_q == FLUSH;
    assign done      = state_q == DONE;
    assign words_out = words_q;
    // A read is safe if the buffer has room for it, or a word leaves this cycle.
    assign fifo_r_en = state_q == RUN && rem_q != '0 && !fifo_empty &&
                       ((count + {1'b0, inflight_q}) < SKID_DEPTH || hs);

    always_comb begin
        state_d = state_q;
        rem_d   = go ? burst_len : rem_q - CNT_W'(fifo_r_en);
        words_d = go ? '0 : words_q + CNT_W'(hs);
        case (state_q)
            IDLE:  state_d = !go ? IDLE : (burst_len == '0) ? DONE : RUN;
            RUN:   state_d = (fifo_r_en && rem_q == CNT_W'(1)) ? FLUSH : RUN;
            FLUSH: state_d = (!inflight_q && (count == 2'd0 || (count == 2'd1 && hs))) ? DONE : FLUSH;
            DONE:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            words_q    <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            words_q    <= words_d;
            inflight_q <= fifo_r_en;
        end
    end

    sync_fifo_drain_skid #(.W(FIFO_WIDTH)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .data_in  (fifo_data),
        .pop      (hs),
        .data_out (m_data),
        .count    (count)
    );

`ifdef SYNC_FIFO_DRAIN_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    assign stall_d      = go ? '0 : (m_valid && !m_ready && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    assign stall_cycles = stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_sync_fifo_drain.sv
// tb_sync_fifo_drain: directed bench with a registered-read FIFO model and stream monitors.
module tb_sync_fifo_drain;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] burst_len = '0;
    logic       busy, done, fifo_r_en, fifo_empty, m_valid;
    logic       m_ready = 1'b1;
    logic [7:0] fifo_data = '0;
    logic [7:0] m_data, words_out;
`ifdef SYNC_FIFO_DRAIN_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    sync_fifo_drain #(.FIFO_WIDTH(8), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .burst_len    (burst_len),
        .busy         (busy),
        .done         (done),
        .fifo_r_en    (fifo_r_en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
`ifdef SYNC_FIFO_DRAIN_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .words_out    (words_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Registered-read FIFO model: data appears the cycle after fifo_r_en.
    logic [7:0] mem [16];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clk) if (fifo_r_en && wp != rp) begin
        fifo_data <= mem[rp % 16];
        rp <= rp + 1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] got [256];
    int hs_cyc [256];
    int got_n = 0, rd_n = 0, done_n = 0, done_cyc = 0, stall_n = 0, stab_err = 0, rfe_err = 0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (m_valid && m_ready) begin
                got[got_n % 256] = m_data;
                hs_cyc[got_n % 256] = cyc;
                got_n++;
            end
            if (fifo_r_en) rd_n++;
            if (fifo_r_en && fifo_empty) rfe_err++;
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (m_valid && !m_ready) stall_n++;
            if (prev_stall && (!m_valid || m_data != prev_data)) stab_err++;
        end
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data = m_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fifo_push(input logic [7:0] d);
        mem[wp % 16] = d;
        wp = wp + 1;
    endtask

    task automatic fifo_clear();
        wp = rp;
    endtask

    task automatic start_burst(input logic [7:0] n, output int s);
        start = 1'b1;
        burst_len = n;
        s = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int lim);
        for (int i = 0; i < lim && done_n == base; i++) tick();
    endtask

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    initial begin
        int s, g0, r0, d0, st0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_valid", m_valid, 0);
        check("rst_words", words_out, 0);
        check("rst_ren", fifo_r_en, 0);
        rst_n = 1'b1;
        tick();

        // Full-rate burst of 8.
        for (int i = 1; i <= 8; i++) fifo_push(8'(i));
        g0 = got_n; r0 = rd_n; d0 = done_n;
        start_burst(8, s);
        wait_done(d0, 40);
        check("t1_done_n", done_n - d0, 1);
        check("t1_count", got_n - g0, 8);
        for (int i = 0; i < 8; i++) check("t1_data", got[g0 + i], i + 1);
        check("t1_first", hs_cyc[g0] - s, 3);
        check("t1_b2b", hs_cyc[g0 + 7] - hs_cyc[g0], 7);
        check("t1_done_at", done_cyc - hs_cyc[g0 + 7], 1);
        check("t1_words", words_out, 8);
        check("t1_reads", rd_n - r0, 8);
        tick();

        // Partial burst leaves words in the FIFO.
        fifo_clear();
        for (int i = 0; i < 5; i++) fifo_push(8'hA0 + 8'(i));
        g0 = got_n; r0 = rd_n; d0 = done_n;
        start_burst(3, s);
        wait_done(d0, 40);
        tick();
        check("t2_done_n", done_n - d0, 1);
        check("t2_count", got_n - g0, 3);
        for (int i = 0; i < 3; i++) check("t2_data", got[g0 + i], 8'hA0 + i);
        check("t2_reads", rd_n - r0, 3);
        check("t2_left", wp - rp, 2);

        // Backpressure with ready pattern 1,0,0,1.
        fifo_clear();
        for (int i = 0; i < 4; i++) fifo_push(8'h31 + 8'(i));
        g0 = got_n; d0 = done_n; st0 = stall_n;
        start_burst(4, s);
        for (int i = 0; i < 60 && done_n == d0; i++) begin
            m_ready = pat[i % 4];
            tick();
        end
        m_ready = 1'b1;
        check("t3_done_n", done_n - d0, 1);
        check("t3_count", got_n - g0, 4);
        for (int i = 0; i < 4; i++) check("t3_data", got[g0 + i], 8'h31 + i);
        check("t3_stable", stab_err, 0);
        check("t3_words", words_out, 4);
`ifdef SYNC_FIFO_DRAIN_STALL_CNT_EN
        check("t3_stall", stall_cycles, stall_n - st0);
`endif
        tick();

        // FIFO empty at start; data arrives later.
        fifo_clear();
        g0 = got_n; r0 = rd_n; d0 = done_n;
        start_burst(2, s);
        for (int i = 0; i < 5; i++) tick();
        check("t4_no_read", rd_n - r0, 0);
        check("t4_busy", busy, 1);
        fifo_push(8'h11);
        fifo_push(8'h22);
        wait_done(d0, 40);
        check("t4_done_n", done_n - d0, 1);
        check("t4_d0", got[g0], 8'h11);
        check("t4_d1", got[g0 + 1], 8'h22);
        check("t4_underflow", rfe_err, 0);
        tick();

        // Zero-length burst.
        fifo_push(8'h99);
        r0 = rd_n; d0 = done_n;
        start_burst(0, s);
        wait_done(d0, 10);
        check("t5_done_n", done_n - d0, 1);
        check("t5_done_at", done_cyc - s, 1);
        check("t5_reads", rd_n - r0, 0);
        tick();

        // Reset mid-burst with the buffer full.
        fifo_clear();
        for (int i = 0; i < 4; i++) fifo_push(8'h41 + 8'(i));
        m_ready = 1'b0;
        d0 = done_n;
        start_burst(4, s);
        for (int i = 0; i < 4; i++) tick();
        check("t6_pre_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("t6_valid", m_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_data", m_data, 0);
        check("t6_ren", fifo_r_en, 0);
        check("t6_done", done, 0);
        tick();
        rst_n = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t6_no_done", done_n - d0, 0);
        fifo_clear();
        fifo_push(8'h55);
        fifo_push(8'h66);
        g0 = got_n; d0 = done_n;
        start_burst(2, s);
        wait_done(d0, 40);
        check("t6_after_n", got_n - g0, 2);
        check("t6_after_d0", got[g0], 8'h55);
        check("t6_after_d1", got[g0 + 1], 8'h66);
        tick();

        // Start while busy is ignored.
        fifo_clear();
        for (int i = 0; i < 6; i++) fifo_push(8'h71 + 8'(i));
        g0 = got_n; r0 = rd_n; d0 = done_n;
        start_burst(3, s);
        tick();
        start_burst(7, s);
        wait_done(d0, 40);
        for (int i = 0; i < 4; i++) tick();
        check("t7_done_n", done_n - d0, 1);
        check("t7_count", got_n - g0, 3);
        check("t7_reads", rd_n - r0, 3);
        check("t7_words", words_out, 3);
        check("t7_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
